// File: rtl/ap_chain_pkg.sv
// Shared types and constants for the ap_chain register-file block:
// handshake state encoding and the read/write select values.
package ap_chain_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic RD = 1'b1;
   localparam logic WR = 1'b0;

   // Width of a down-counter that must hold values 0..n-1; never zero-width.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ap_chain_ctrl.sv
// ap_ctrl_chain handshake FSM with latency counter; emits a one-cycle
// commit strobe and counts acknowledged transactions.
module ap_chain_ctrl
   import ap_chain_pkg::*;
#(
   parameter int LATENCY = 3,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             ap_rst,
   input  logic             ap_start,
   input  logic             ap_continue,
   input  logic             ap_ce,
   output logic             ap_idle,
   output logic             ap_ready,
   output logic             ap_done,
   output logic             commit,
   output logic [CNT_W-1:0] txn_cnt
);

   localparam int LAT_W = cnt_width(LATENCY);
   localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(LATENCY - 1);

   state_t           state, state_nxt;
   logic [LAT_W-1:0] lat_cnt, lat_cnt_nxt;
   logic             txn_inc;

   // NOTE: every output of this block is given a default first, so no
   // path through the case statement can leave one unassigned (no latches).
   always_comb begin
      state_nxt   = state;
      lat_cnt_nxt = lat_cnt;
      txn_inc     = 1'b0;
      commit      = 1'b0;
      ap_ready    = 1'b0;
      case (state)
         IDLE: begin
            if (ap_start && ap_ce) begin
               ap_ready    = 1'b1;
               state_nxt   = BUSY;
               lat_cnt_nxt = LAT_INIT;
            end
         end
         BUSY: begin
            if (ap_ce) begin
               if (lat_cnt == '0) begin
                  commit    = 1'b1;
                  state_nxt = DONE;
               end else begin
                  lat_cnt_nxt = lat_cnt - 1'b1;
               end
            end
         end
         DONE: begin
            if (ap_continue && ap_ce) begin
               state_nxt = IDLE;
               txn_inc   = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop
   // samples the pre-edge value of its neighbours.
   always_ff @(posedge clk) begin
      if (ap_rst) begin
         state   <= IDLE;
         lat_cnt <= '0;
         txn_cnt <= '0;
      end else begin
         state   <= state_nxt;
         lat_cnt <= lat_cnt_nxt;
         if (txn_inc) txn_cnt <= txn_cnt + 1'b1;
      end
   end

   assign ap_idle = (state == IDLE);
   assign ap_done = (state == DONE);

endmodule

// File: rtl/ap_chain_regfile.sv
// Register file behind an ap_ctrl_chain handshake: one read or write per
// transaction, committed LATENCY enabled cycles after the start is accepted.
module ap_chain_regfile
   import ap_chain_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int DEPTH   = 16,
   parameter int LATENCY = 3,
   parameter int CNT_W   = 16
) (
   input  logic              clk,
   input  logic              ap_rst,
   input  logic [31:0]       addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_wr,
   input  logic              ap_start,
   input  logic              ap_continue,
   input  logic              ap_ce,
   output logic [DATA_W-1:0] ap_return,
   output logic              ap_idle,
   output logic              ap_ready,
   output logic              ap_done,
   output logic              ap_err,
   output logic [CNT_W-1:0]  txn_cnt
);

   localparam int IDX_W = $clog2(DEPTH);

   logic              commit;
   logic [31:0]       addr_q;
   logic [DATA_W-1:0] data_q;
   logic              rd_wr_q;
   logic              addr_ok;
   logic [IDX_W-1:0]  idx;
   logic [DATA_W-1:0] mem [DEPTH];

   ap_chain_ctrl #(
      .LATENCY (LATENCY),
      .CNT_W   (CNT_W)
   ) u_ctrl (
      .clk         (clk),
      .ap_rst      (ap_rst),
      .ap_start    (ap_start),
      .ap_continue (ap_continue),
      .ap_ce       (ap_ce),
      .ap_idle     (ap_idle),
      .ap_ready    (ap_ready),
      .ap_done     (ap_done),
      .commit      (commit),
      .txn_cnt     (txn_cnt)
   );

   // Inputs are sampled only on the accept strobe; later changes are ignored.
   always_ff @(posedge clk) begin
      if (ap_rst) begin
         addr_q  <= '0;
         data_q  <= '0;
         rd_wr_q <= RD;
      end else if (ap_ready) begin
         addr_q  <= addr;
         data_q  <= wr_data;
         rd_wr_q <= rd_wr;
      end
   end

   // Full 32-bit compare: high address bits must not alias onto valid words.
   assign addr_ok = (addr_q < 32'(DEPTH));
   assign idx     = addr_q[IDX_W-1:0];

   // NOTE: the storage is cleared on reset because every word must read 0
   // afterwards; this keeps it in flops rather than a RAM macro.
   always_ff @(posedge clk) begin
      if (ap_rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         ap_return <= '0;
         ap_err    <= 1'b0;
      end else if (commit) begin
         if (addr_ok) begin
            ap_err <= 1'b0;
            if (rd_wr_q == RD) ap_return <= mem[idx];
            else               mem[idx]  <= data_q;
         end else begin
            ap_err <= 1'b1;
            if (rd_wr_q == RD) ap_return <= '0;
         end
      end
   end

endmodule

// File: tb/tb_ap_chain_regfile.sv
// Self-checking bench for ap_chain_regfile: directed scenarios plus random
// transactions compared against an array-based reference model.
module tb_ap_chain_regfile;

   localparam int DATA_W  = 32;
   localparam int DEPTH   = 16;
   localparam int LATENCY = 3;

   logic        clk = 1'b0;
   logic        ap_rst;
   logic [31:0] addr;
   logic [31:0] wr_data;
   logic        rd_wr;
   logic        ap_start;
   logic        ap_continue;
   logic        ap_ce;

   logic [31:0] ap_return, ap_return2;
   logic        ap_idle, ap_ready, ap_done, ap_err;
   logic        ap_idle2, ap_ready2, ap_done2, ap_err2;
   logic [15:0] txn_cnt;
   logic [1:0]  txn_cnt2;

   int passed = 0;
   int total  = 0;

   // Reference model
   logic [31:0] m_mem [DEPTH];
   logic [31:0] m_ret;
   logic        m_err;
   int          m_cnt;

   always #5 clk = ~clk;

   ap_chain_regfile #(
      .DATA_W(DATA_W), .DEPTH(DEPTH), .LATENCY(LATENCY), .CNT_W(16)
   ) dut (
      .clk(clk), .ap_rst(ap_rst), .addr(addr), .wr_data(wr_data),
      .rd_wr(rd_wr), .ap_start(ap_start), .ap_continue(ap_continue),
      .ap_ce(ap_ce), .ap_return(ap_return), .ap_idle(ap_idle),
      .ap_ready(ap_ready), .ap_done(ap_done), .ap_err(ap_err),
      .txn_cnt(txn_cnt)
   );

   ap_chain_regfile #(
      .DATA_W(DATA_W), .DEPTH(DEPTH), .LATENCY(LATENCY), .CNT_W(2)
   ) dut2 (
      .clk(clk), .ap_rst(ap_rst), .addr(addr), .wr_data(wr_data),
      .rd_wr(rd_wr), .ap_start(ap_start), .ap_continue(ap_continue),
      .ap_ce(ap_ce), .ap_return(ap_return2), .ap_idle(ap_idle2),
      .ap_ready(ap_ready2), .ap_done(ap_done2), .ap_err(ap_err2),
      .txn_cnt(txn_cnt2)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      m_ret = '0;
      m_err = 1'b0;
      m_cnt = 0;
   endtask

   task automatic model_apply(input logic [31:0] a, input logic [31:0] d, input logic rd);
      if (a < DEPTH) begin
         m_err = 1'b0;
         if (rd) m_ret = m_mem[a];
         else    m_mem[a] = d;
      end else begin
         m_err = 1'b1;
         if (rd) m_ret = '0;
      end
   endtask

   // One full transaction: accept, optional ce gap after the first busy
   // cycle, optional hold in DONE with spurious starts, then acknowledge.
   task automatic txn(input logic [31:0] a, input logic [31:0] d, input logic rd,
                      input int drop, input int hold);
      int steps;
      check("idle_before_start", ap_idle, 1'b1);
      addr = a; wr_data = d; rd_wr = rd; ap_start = 1'b1; ap_ce = 1'b1;
      #1;
      check("ready_on_accept", ap_ready, 1'b1);
      @(negedge clk);
      ap_start = 1'b0;
      addr = $urandom; wr_data = $urandom; rd_wr = 1'($urandom);
      check("ready_after_accept", ap_ready, 1'b0);
      steps = LATENCY + drop;
      for (int j = 1; j <= steps; j++) begin
         ap_ce = !(drop > 0 && j >= 2 && j < 2 + drop);
         @(negedge clk);
         if (j < steps) begin
            total++;
            assert (ap_done === 1'b0) passed++;
            else $error("FAIL done_early: cycle=%0d observed=%0b expected=0", j, ap_done);
         end
      end
      ap_ce = 1'b1;
      model_apply(a, d, rd);
      check("done_on_time", ap_done, 1'b1);
      check("ap_return", ap_return, m_ret);
      check("ap_err", ap_err, m_err);
      for (int h = 0; h < hold; h++) begin
         ap_start = 1'b1; addr = $urandom; rd_wr = 1'($urandom);
         #1;
         check("ready_in_done", ap_ready, 1'b0);
         @(negedge clk);
         check("done_held", ap_done, 1'b1);
         check("return_held", ap_return, m_ret);
      end
      ap_start = 1'b0;
      ap_continue = 1'b1;
      @(negedge clk);
      ap_continue = 1'b0;
      m_cnt++;
      check("idle_after_continue", ap_idle, 1'b1);
      check("txn_cnt", txn_cnt, 64'(m_cnt % 65536));
      check("txn_cnt_w2", txn_cnt2, 64'(m_cnt % 4));
   endtask

   initial begin
      ap_rst = 1'b1; addr = '0; wr_data = '0; rd_wr = 1'b0;
      ap_start = 1'b1; ap_continue = 1'b0; ap_ce = 1'b1;
      model_reset();
      repeat (2) @(negedge clk);
      ap_start = 1'b0;
      #1;
      check("rst_idle", ap_idle, 1'b1);
      check("rst_done", ap_done, 1'b0);
      check("rst_ready", ap_ready, 1'b0);
      check("rst_return", ap_return, 32'h0);
      check("rst_err", ap_err, 1'b0);
      check("rst_txn_cnt", txn_cnt, 16'h0);
      @(negedge clk);
      ap_rst = 1'b0;

      // Write then read back the same word
      txn(32'd0, 32'h7216, 1'b0, 0, 0);
      txn(32'd0, 32'h0, 1'b1, 0, 0);
      check("wr_rd_value", ap_return, 32'h7216);
      check("wr_rd_cnt", txn_cnt, 16'd2);

      // Top valid word and out-of-range addresses
      txn(32'd15, 32'hDEAD, 1'b0, 0, 0);
      txn(32'd16, 32'h0, 1'b1, 0, 0);
      check("oob16_err", ap_err, 1'b1);
      txn(32'hFFFF_FFFF, 32'h0, 1'b1, 0, 0);
      check("oobmax_ret", ap_return, 32'h0);
      txn(32'd15, 32'h0, 1'b1, 0, 0);
      check("rd15_value", ap_return, 32'hDEAD);
      check("rd15_err", ap_err, 1'b0);

      // Long hold in DONE, then a ce gap while busy
      txn(32'd5, 32'h1234_5678, 1'b1, 0, 10);
      txn(32'd5, 32'hCAFE_F00D, 1'b0, 5, 0);
      txn(32'd5, 32'h0, 1'b1, 5, 2);
      check("ce_gap_value", ap_return, 32'hCAFE_F00D);

      // Reset one cycle into a write aborts it
      addr = 32'd3; wr_data = 32'h55; rd_wr = 1'b0; ap_start = 1'b1; ap_ce = 1'b1;
      @(negedge clk);
      ap_start = 1'b0;
      @(negedge clk);
      ap_rst = 1'b1;
      @(negedge clk);
      ap_rst = 1'b0;
      model_reset();
      check("abort_idle", ap_idle, 1'b1);
      check("abort_txn_cnt", txn_cnt, 16'h0);
      check("abort_return", ap_return, 32'h0);
      txn(32'd3, 32'h0, 1'b1, 0, 0);
      check("abort_rd3", ap_return, 32'h0);
      txn(32'd0, 32'h0, 1'b1, 0, 0);
      check("abort_rd0", ap_return, 32'h0);

      // Random mix against the model
      for (int n = 0; n < 40; n++) begin
         logic [31:0] a;
         a = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, DEPTH + 3));
         txn(a, $urandom, 1'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time budget");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/ap_chain_regfile.md
AP_CHAIN_REGFILE -- requirements
Module: ap_chain_regfile

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, the data width of wr_data, ap_return and each storage word.
REQ-002 The block SHALL have parameter DEPTH, default 16, the number of storage words (at least 2).
REQ-003 The block SHALL have parameter LATENCY, default 3, the number of enabled cycles from start acceptance to done (at least 1).
REQ-004 The block SHALL have parameter CNT_W, default 16, the width of the completed-transaction counter.
REQ-005 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port ap_rst, input, 1 bit, a synchronous, active-high reset.
REQ-007 The block SHALL have port addr, input, 32 bits, the word index.
REQ-008 The block SHALL have port wr_data, input, DATA_W bits, the write data.
REQ-009 The block SHALL have port rd_wr, input, 1 bit, the operation select: 1 = read, 0 = write.
REQ-010 The block SHALL have port ap_start, input, 1 bit, the transaction request.
REQ-011 The block SHALL have port ap_continue, input, 1 bit, the acknowledge of done by downstream.
REQ-012 The block SHALL have port ap_ce, input, 1 bit, the clock enable; 0 freezes the block.
REQ-013 The block SHALL have port ap_return, output, DATA_W bits, the read result.
REQ-014 The block SHALL have port ap_idle, output, 1 bit, high when the block can accept a start.
REQ-015 The block SHALL have port ap_ready, output, 1 bit, a one-cycle input-capture strobe.
REQ-016 The block SHALL have port ap_done, output, 1 bit, high when a transaction has completed and is not yet acknowledged.
REQ-017 The block SHALL have port ap_err, output, 1 bit, high when the completed transaction had addr >= DEPTH.
REQ-018 The block SHALL have port txn_cnt, output, CNT_W bits, the count of acknowledged transactions.

Function
REQ-019 The FSM SHALL have exactly three states: IDLE, BUSY and DONE; ap_idle = (state == IDLE); ap_done = (state == DONE).
REQ-020 In IDLE, ap_start=1 with ap_ce=1 SHALL capture addr, wr_data and rd_wr, and SHALL move the FSM to BUSY with the latency counter loaded to LATENCY-1.
REQ-021 ap_ready SHALL be combinational: state==IDLE && ap_start && ap_ce, and 0 at all other times.
REQ-022 In BUSY, the latency counter SHALL decrement on each cycle with ap_ce=1.
REQ-023 In the BUSY cycle where the counter is 0 and ap_ce=1, the block SHALL commit the operation and move to DONE.
REQ-024 If start is accepted at edge T, ap_done SHALL first be high after edge T+LATENCY.
REQ-025 On a write commit with a valid address, mem[addr] SHALL take the captured wr_data, and ap_return SHALL be unchanged.
REQ-026 On a read commit with a valid address, ap_return SHALL take mem[addr].
REQ-027 A read of a word written by the immediately preceding transaction SHALL return the new value.
REQ-028 For an invalid address (captured addr >= DEPTH, full 32-bit compare), a write SHALL be dropped, a read SHALL set ap_return to 0, and ap_err SHALL be set.
REQ-029 For a valid address, ap_err SHALL be cleared at commit.
REQ-030 ap_return and ap_err SHALL hold their values from commit until the next commit.
REQ-031 In DONE, ap_continue=1 with ap_ce=1 SHALL move the FSM to IDLE and increment txn_cnt, wrapping modulo 2^CNT_W; otherwise the FSM SHALL stay in DONE indefinitely.
REQ-032 ap_start in DONE SHALL be ignored; a new start SHALL be accepted no earlier than the first IDLE cycle.
REQ-033 While ap_ce=0, the state, counter, storage, captured inputs, ap_return, ap_err and txn_cnt SHALL all be held.
REQ-034 Inputs SHALL be sampled only at capture; changes to addr, wr_data or rd_wr during BUSY or DONE SHALL have no effect.

Reset
REQ-035 ap_rst=1 at an edge SHALL force: state IDLE, counter 0, ap_return 0, ap_err 0, txn_cnt 0, and all mem words 0.
REQ-036 ap_rst SHALL override ap_ce and ap_start.
REQ-037 After reset, ap_idle=1, ap_done=0 and ap_ready=0 unless ap_start && ap_ce.
REQ-038 A reset during BUSY SHALL abort the transaction with no storage write.

Structure
REQ-039 Package ap_chain_pkg SHALL hold the state enum (IDLE, BUSY, DONE) and the constants RD=1'b1 and WR=1'b0.
REQ-040 The handshake FSM and latency counter SHALL be one sub-module, ap_chain_ctrl, which issues a single-cycle commit strobe.
REQ-041 The storage and the return/error registers SHALL be implemented in the top module.

Verification (DATA_W=32, DEPTH=16, LATENCY=3)
REQ-042 Write 0x7216 to addr 0, then read addr 0 -> ap_return=0x7216, ap_err=0, done 3 cycles after each ap_ready, txn_cnt=2.
REQ-043 Write 0xDEAD to addr 15, then read addr 16 and addr 0xFFFFFFFF -> ap_return=0 and ap_err=1 for both reads; a read of addr 15 then returns 0xDEAD with ap_err=0.
REQ-044 Hold ap_continue=0 for 10 cycles after done -> ap_done stays 1, ap_return is stable, and ap_start is ignored; after continue, the next transaction is accepted on the first IDLE cycle.
REQ-045 Drop ap_ce for 5 cycles mid-BUSY -> ap_done is delayed by exactly 5 cycles and the data is correct.
REQ-046 Assert ap_rst one cycle into a write of 0x55 to addr 3 -> a read of addr 3 returns 0, and txn_cnt=0 before that read.
REQ-047 With CNT_W=2, complete 5 transactions -> txn_cnt sequence is 1, 2, 3, 0, 1.
